// File: rtl/lut_neuron_pipe_if.sv
// Bundle of lookup and table-configuration signals for lut_neuron_pipe.
// master drives requests, configuration and downstream ready; slave is the neuron.
interface lut_neuron_pipe_if #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [IN_BITS-1:0]  in_data;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic                cfg_start;
  logic                cfg_valid;
  logic [OUT_BITS-1:0] cfg_data;
  logic                cfg_busy;
  logic                cfg_done;

  modport master (
    output in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
    input  in_ready, out_valid, out_data, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_start, cfg_valid, cfg_data,
    output in_ready, out_valid, out_data, cfg_busy, cfg_done
  );
endinterface

// File: rtl/lut_neuron_pipe.sv
// Runtime-reloadable truth-table neuron: a 2^IN_BITS x OUT_BITS table held in
// flops, read through a 2-stage valid/ready pipeline and rewritten by an
// auto-incrementing configuration stream.
module lut_neuron_pipe #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input logic               clk,
  input logic               rst,
  lut_neuron_pipe_if.slave  bus
);

  localparam int                 DEPTH    = 1 << IN_BITS;
  localparam logic [IN_BITS-1:0] PTR_LAST = '1;
  localparam logic [IN_BITS-1:0] PTR_ONE  = IN_BITS'(1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IN_BITS-1:0]  ptr_q, ptr_d;
  logic                wr_en;
  logic                done_d;
  logic                cfg_done_q;

  logic [OUT_BITS-1:0] tbl [DEPTH];

  logic                s1_valid;
  logic [IN_BITS-1:0]  s1_addr;
  logic                s2_valid;
  logic [OUT_BITS-1:0] out_data_q;

  logic                adv;
  logic                accept;

  // The whole pipe moves together: it stalls only when a result is stuck at the output.
  assign adv    = !s2_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = rst && (state_q == IDLE) && adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = out_data_q;
  assign bus.cfg_busy  = (state_q == LOAD);
  assign bus.cfg_done  = cfg_done_q;

  // Load controller: a start is only honoured with stage 1 empty and no lookup
  // being accepted, so no request can straddle a reload; a start while loading
  // rewinds the pointer, and the final word returns to IDLE with a done pulse.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start && !s1_valid && !accept) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      LOAD: begin
        if (bus.cfg_start) begin
          ptr_d = '0;
        end else if (bus.cfg_valid) begin
          wr_en = 1'b1;
          if (ptr_q == PTR_LAST) begin
            state_d = IDLE;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Controller state, write pointer and the registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cfg_done_q <= done_d;
    end
  end

  // Table storage: cleared by reset so an aborted load never leaves stale weights.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else if (wr_en) begin
      tbl[ptr_q] <= bus.cfg_data;
    end
  end

  // Stage 1 captures the accepted address; it empties whenever the pipe advances idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr <= bus.in_data;
      end
    end
  end

  // Stage 2 performs the table read; out_data keeps its last word when nothing moves in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid   <= 1'b0;
      out_data_q <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_data_q <= tbl[s1_addr];
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_pipe.sv
// Bench for lut_neuron_pipe: a table-plus-queue model scores every result of the
// 6/2 instance, directed literals pin the model, and a 4/3 instance covers reparametrisation.
module tb_lut_neuron_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  lut_neuron_pipe_if #(.IN_BITS(6), .OUT_BITS(2)) bus ();
  lut_neuron_pipe_if #(.IN_BITS(4), .OUT_BITS(3)) bus2 ();

  lut_neuron_pipe #(.IN_BITS(6), .OUT_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  lut_neuron_pipe #(.IN_BITS(4), .OUT_BITS(3)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_recv = 0;
  logic [1:0]  ref_tbl  [64];
  logic [1:0]  load_buf [64];
  logic [1:0]  exp_q [$];
  logic        prev_stall = 1'b0;
  logic [1:0]  prev_data  = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a table of what was loaded and a queue of results owed, in acceptance order.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_result", 32'd1, 32'd0);
        end else begin
          checkOutput("model_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
          n_recv++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_tbl[bus.in_data]);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  // Present one request and hold it until it is accepted.
  task automatic applyStimulus(input logic [5:0] addr);
    int w;
    w = 0;
    bus.in_data  = addr;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && w < 20) begin
      tick();
      w++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic waitOut();
    int w;
    w = 0;
    while (!bus.out_valid && w < 10) begin
      tick();
      w++;
    end
    if (!bus.out_valid) checkOutput("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic lookupExpect(input string name, input logic [5:0] addr, input logic [1:0] exp);
    applyStimulus(addr);
    waitOut();
    checkOutput(name, 32'(bus.out_data), 32'(exp));
  endtask

  // Stream load_buf[0..n-1] with a cfg_valid gap every third cycle; a full load updates the model.
  task automatic loadTable(input int n);
    int k;
    int cyc;
    int tries;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    tries = 0;
    while (!bus.cfg_busy && tries < 5) begin
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      tries++;
    end
    checkOutput("load_enter", 32'(bus.cfg_busy), 32'd1);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 400) begin
      bus.cfg_valid = (cyc % 3 != 2);
      bus.cfg_data  = load_buf[k];
      tick();
      if (bus.cfg_valid) k++;
      cyc++;
      if (k < 64) begin
        checkOutput("busy_during_load", 32'(bus.cfg_busy), 32'd1);
        checkOutput("no_early_done", 32'(bus.cfg_done), 32'd0);
      end
    end
    bus.cfg_valid = 1'b0;
    if (k < n) checkOutput("load_timeout", 32'd0, 32'd1);
    if (n == 64) begin
      checkOutput("done_pulse", 32'(bus.cfg_done), 32'd1);
      checkOutput("busy_cleared", 32'(bus.cfg_busy), 32'd0);
      for (int i = 0; i < 64; i++) ref_tbl[i] = load_buf[i];
      tick();
      checkOutput("done_one_cycle", 32'(bus.cfg_done), 32'd0);
    end
  endtask

  task automatic lookup2(input string name, input logic [3:0] addr, input logic [2:0] exp);
    bus2.in_data  = addr;
    bus2.in_valid = 1'b1;
    #1;
    checkOutput({name, "_ready"}, 32'(bus2.in_ready), 32'd1);
    tick();
    bus2.in_valid = 1'b0;
    tick();
    checkOutput({name, "_valid"}, 32'(bus2.out_valid), 32'd1);
    checkOutput(name, 32'(bus2.out_data), 32'(exp));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int sent;
    int cyc;
    int base;
    int w;
    logic acc;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;
    bus2.cfg_start = 1'b0;
    bus2.cfg_valid = 1'b0;
    bus2.cfg_data  = '0;
    for (int i = 0; i < 64; i++) ref_tbl[i] = '0;

    // 1: reset state, then a lookup of address 4 on the all-zero table with 2-cycle latency
    tick();
    tick();
    checkOutput("t1_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t1_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t1_rst_out_data", 32'(bus.out_data), 32'd0);
    checkOutput("t1_rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
    checkOutput("t1_rst_cfg_done", 32'(bus.cfg_done), 32'd0);
    rst = 1'b1;
    #1;
    checkOutput("t1_ready_after_release", 32'(bus.in_ready), 32'd1);
    bus.in_data  = 6'b000100;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    checkOutput("t1_latency_c1", 32'(bus.out_valid), 32'd0);
    tick();
    checkOutput("t1_latency_c2", 32'(bus.out_valid), 32'd1);
    checkOutput("t1_data", 32'(bus.out_data), 32'd0);
    tick();

    // 2: load word k = k[1:0], then read a few addresses back
    for (int k = 0; k < 64; k++) load_buf[k] = 2'(k);
    loadTable(64);
    lookupExpect("t2_addr_12", 6'b001100, 2'b00);
    lookupExpect("t2_addr_6", 6'b000110, 2'b10);
    lookupExpect("t2_addr_63", 6'b111111, 2'b11);
    tick();

    // 3: ten back-to-back lookups with a 3-cycle downstream stall mid-stream
    base = n_recv;
    sent = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 6'd3;
    while (sent < 10 && cyc < 60) begin
      bus.out_ready = !(cyc >= 4 && cyc < 7);
      #1;
      if (cyc == 5) checkOutput("t3_in_ready_stall", 32'(bus.in_ready), 32'd0);
      acc = bus.in_ready;
      tick();
      cyc++;
      if (acc) begin
        sent++;
        bus.in_data = 6'((sent * 7 + 3) % 64);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    w = 0;
    while (n_recv < base + 10 && w < 20) begin
      tick();
      w++;
    end
    checkOutput("t3_count", 32'(n_recv - base), 32'd10);
    checkOutput("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // 4: cfg_start alongside an accepted lookup is ignored, a later start enters LOAD
    bus.in_data   = 6'd6;
    bus.in_valid  = 1'b1;
    bus.cfg_start = 1'b1;
    #1;
    checkOutput("t4_accept_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    checkOutput("t4_start_ignored", 32'(bus.cfg_busy), 32'd0);
    checkOutput("t4_result_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t4_result_data", 32'(bus.out_data), 32'd2);
    tick();
    bus.cfg_start = 1'b0;
    checkOutput("t4_load_busy", 32'(bus.cfg_busy), 32'd1);
    checkOutput("t4_load_in_ready", 32'(bus.in_ready), 32'd0);
    for (int k = 0; k < 64; k++) load_buf[k] = 2'(k >> 2);
    loadTable(64);
    lookupExpect("t4_addr_12", 6'b001100, 2'b11);
    tick();

    // 5: reset in the middle of a load while a result is stalled at the output
    applyStimulus(6'd5);
    bus.out_ready = 1'b0;
    tick();
    checkOutput("t5_stalled_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("t5_stalled_data", 32'(bus.out_data), 32'd1);
    for (int k = 0; k < 64; k++) load_buf[k] = 2'b11;
    loadTable(20);
    rst = 1'b0;
    #1;
    checkOutput("t5_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("t5_rst_cfg_busy", 32'(bus.cfg_busy), 32'd0);
    checkOutput("t5_rst_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t5_rst_out_data", 32'(bus.out_data), 32'd0);
    for (int i = 0; i < 64; i++) ref_tbl[i] = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("t5_ready_after_release", 32'(bus.in_ready), 32'd1);
    lookupExpect("t5_zero_63", 6'b111111, 2'b00);
    lookupExpect("t5_zero_6", 6'b000110, 2'b00);
    tick();
    for (int k = 0; k < 64; k++) load_buf[k] = 2'(k >> 4);
    loadTable(64);
    lookupExpect("t5_reload_63", 6'b111111, 2'b11);
    lookupExpect("t5_reload_16", 6'b010000, 2'b01);
    tick();

    // 6: 16-entry, 3-bit instance loaded with 7,6,5,... (wrapping)
    bus2.cfg_start = 1'b1;
    tick();
    bus2.cfg_start = 1'b0;
    checkOutput("t6_busy", 32'(bus2.cfg_busy), 32'd1);
    for (int k = 0; k < 16; k++) begin
      bus2.cfg_valid = 1'b1;
      bus2.cfg_data  = 3'(7 - k);
      tick();
      if (k < 15) checkOutput("t6_no_early_done", 32'(bus2.cfg_done), 32'd0);
    end
    bus2.cfg_valid = 1'b0;
    checkOutput("t6_done", 32'(bus2.cfg_done), 32'd1);
    checkOutput("t6_busy_cleared", 32'(bus2.cfg_busy), 32'd0);
    lookup2("t6_addr_1", 4'd1, 3'b110);
    lookup2("t6_addr_0", 4'd0, 3'b111);
    lookup2("t6_addr_15", 4'd15, 3'b000);
    lookup2("t6_addr_9", 4'd9, 3'b110);

    tick();
    tick();
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
